// File: rtl/pipelined_alu.sv
// rtl/pipelined_alu.sv - two-stage valid/ready pipelined ALU with flags, sticky overflow and op counter
module pipelined_alu #(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [3:0]         F,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   Y,
  output logic               Overflow,
  output logic               Zero,
  output logic               Carry,
  output logic               Illegal,
  input  logic               clear,
  output logic               sticky_ovf,
  output logic [COUNT_W-1:0] op_count
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_ANDN = 4'b0100;
  localparam logic [3:0] OP_ORN  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1001;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_SRL  = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1100;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [3:0]       s1_f;
  logic             s2_valid;

  logic             s1_load;
  logic             s2_load;
  logic             deliver;

  logic             sub_op;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH:0]   sum;
  logic             add_ovf;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] y_n;
  logic             ovf_n;
  logic             carry_n;
  logic             illegal_n;
  logic             zero_n;

  // s1 may refill in the same cycle it drains into s2
  assign in_ready  = !s1_valid || !s2_valid || out_ready;
  assign s1_load   = in_valid && in_ready;
  assign s2_load   = s1_valid && (!s2_valid || out_ready);
  assign deliver   = s2_valid && out_ready;
  assign out_valid = s2_valid;

  always_comb begin
    sub_op    = (s1_f == OP_SUB) || (s1_f == OP_SLT);
    add_b     = sub_op ? ~s1_b : s1_b;
    sum       = {1'b0, s1_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, sub_op};
    add_ovf   = (s1_a[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
    shamt     = s1_b[SHW-1:0];
    y_n       = '0;
    ovf_n     = 1'b0;
    carry_n   = 1'b0;
    illegal_n = 1'b0;
    case (s1_f)
      OP_AND:  y_n = s1_a & s1_b;
      OP_OR:   y_n = s1_a | s1_b;
      OP_ADD, OP_SUB: begin
        y_n     = sum[WIDTH-1:0];
        ovf_n   = add_ovf;
        carry_n = sum[WIDTH];
      end
      OP_ANDN: y_n = s1_a & ~s1_b;
      OP_ORN:  y_n = s1_a | ~s1_b;
      // true sign of A-B stays correct when the subtraction overflows
      OP_SLT: begin
        y_n     = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
        carry_n = sum[WIDTH];
      end
      OP_XOR:  y_n = s1_a ^ s1_b;
      OP_NOR:  y_n = ~(s1_a | s1_b);
      OP_SLL:  y_n = s1_a << shamt;
      OP_SRL:  y_n = s1_a >> shamt;
      OP_SRA:  y_n = $unsigned($signed(s1_a) >>> shamt);
      default: illegal_n = 1'b1;
    endcase
    zero_n = (y_n == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_f     <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_a     <= A;
        s1_b     <= B;
        s1_f     <= F;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      Y        <= '0;
      Overflow <= 1'b0;
      Zero     <= 1'b0;
      Carry    <= 1'b0;
      Illegal  <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid <= 1'b1;
        Y        <= y_n;
        Overflow <= ovf_n;
        Zero     <= zero_n;
        Carry    <= carry_n;
        Illegal  <= illegal_n;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  // clear wins over a simultaneous delivery
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sticky_ovf <= 1'b0;
      op_count   <= '0;
    end else if (clear) begin
      sticky_ovf <= 1'b0;
      op_count   <= '0;
    end else if (deliver) begin
      sticky_ovf <= sticky_ovf | Overflow;
      op_count   <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipelined_alu.sv
// tb/tb_pipelined_alu.sv - directed self-checking bench for pipelined_alu
module tb_pipelined_alu;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  F;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Y;
  logic        Overflow;
  logic        Zero;
  logic        Carry;
  logic        Illegal;
  logic        clear;
  logic        sticky_ovf;
  logic [15:0] op_count;

  int checks;
  int errors;

  pipelined_alu #(.WIDTH(32), .COUNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .F(F), .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .Overflow(Overflow), .Zero(Zero), .Carry(Carry), .Illegal(Illegal),
    .clear(clear), .sticky_ovf(sticky_ovf), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // presents one beat and waits until it sits in s2 (out_ready assumed high)
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
    A = a; B = b; F = f; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle_clear(input int n);
    in_valid = 1'b0; out_ready = 1'b1; clear = 1'b1;
    repeat (n) @(posedge clk);
    #1 clear = 1'b0;
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, Overflow, Zero, Carry, Illegal, sticky_ovf} !== 6'b0 || Y !== 32'h0 || op_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_state valid=%b Y=%h flags=%b%b%b%b sticky=%b cnt=%0d required all zero",
               out_valid, Y, Overflow, Zero, Carry, Illegal, sticky_ovf, op_count);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b required 1", in_ready); end
  endtask

  task automatic test_add;
    issue(32'h7FFFFFFF, 32'h00000001, 4'b0010);
    checks++;
    if (out_valid !== 1'b1 || Y !== 32'h80000000 || {Overflow, Carry, Zero, Illegal} !== 4'b1000) begin
      errors++;
      $display("FAIL add_ovf valid=%b Y=%h OCZI=%b%b%b%b required 1 80000000 1000",
               out_valid, Y, Overflow, Carry, Zero, Illegal);
    end
    @(posedge clk); #1;
    checks++;
    if (sticky_ovf !== 1'b1 || op_count !== 16'd1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_deliver sticky=%b cnt=%0d valid=%b required 1 1 0", sticky_ovf, op_count, out_valid);
    end
    issue(32'hFFFFFFFF, 32'h00000001, 4'b0010);
    checks++;
    if (Y !== 32'h0 || {Overflow, Carry, Zero, Illegal} !== 4'b0110) begin
      errors++;
      $display("FAIL add_carry Y=%h OCZI=%b%b%b%b required 0 0110", Y, Overflow, Carry, Zero, Illegal);
    end
  endtask

  task automatic test_sub_slt;
    issue(32'd5, 32'd5, 4'b0110);
    checks++;
    if (Y !== 32'h0 || {Overflow, Carry, Zero, Illegal} !== 4'b0110) begin
      errors++;
      $display("FAIL sub_equal Y=%h OCZI=%b%b%b%b required 0 0110", Y, Overflow, Carry, Zero, Illegal);
    end
    issue(32'h80000000, 32'd1, 4'b0111);
    checks++;
    if (Y !== 32'h1 || {Overflow, Carry, Zero, Illegal} !== 4'b0100) begin
      errors++;
      $display("FAIL slt_overflow Y=%h OCZI=%b%b%b%b required 1 0100", Y, Overflow, Carry, Zero, Illegal);
    end
    issue(32'd3, 32'hFFFFFFFF, 4'b0111);
    checks++;
    if (Y !== 32'h0 || {Overflow, Carry, Zero, Illegal} !== 4'b0010) begin
      errors++;
      $display("FAIL slt_false Y=%h OCZI=%b%b%b%b required 0 0010", Y, Overflow, Carry, Zero, Illegal);
    end
    issue(32'h80000000, 32'd1, 4'b0110);
    checks++;
    if (Y !== 32'h7FFFFFFF || {Overflow, Carry, Zero, Illegal} !== 4'b1100) begin
      errors++;
      $display("FAIL sub_overflow Y=%h OCZI=%b%b%b%b required 7fffffff 1100", Y, Overflow, Carry, Zero, Illegal);
    end
  endtask

  task automatic test_logic;
    logic [31:0] ta [6];
    logic [31:0] tb [6];
    logic [3:0]  tf [6];
    logic [31:0] te [6];
    tf = '{4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b1000, 4'b1001};
    te = '{32'h0F000F00, 32'hFFF0FFF0, 32'hF000F000, 32'hFF0FFF0F, 32'hF0F0F0F0, 32'h000F000F};
    for (int i = 0; i < 6; i++) begin
      ta[i] = 32'hFF00FF00;
      tb[i] = 32'h0FF00FF0;
    end
    for (int i = 0; i < 6; i++) begin
      issue(ta[i], tb[i], tf[i]);
      checks++;
      if (Y !== te[i] || {Overflow, Carry, Illegal} !== 3'b000 || Zero !== (te[i] == 32'h0)) begin
        errors++;
        $display("FAIL logic_op%0d F=%b Y=%h OCZI=%b%b%b%b required %h", i, tf[i], Y,
                 Overflow, Carry, Zero, Illegal, te[i]);
      end
    end
  endtask

  task automatic test_shift;
    issue(32'hF0000000, 32'h00000024, 4'b1100);
    checks++;
    if (Y !== 32'hFF000000 || {Overflow, Carry, Zero, Illegal} !== 4'b0000) begin
      errors++; $display("FAIL sra Y=%h required ff000000", Y);
    end
    issue(32'hF0000000, 32'h00000024, 4'b1011);
    checks++;
    if (Y !== 32'h0F000000) begin errors++; $display("FAIL srl Y=%h required 0f000000", Y); end
    issue(32'h12345678, 32'hFFFFFFE4, 4'b1010);
    checks++;
    if (Y !== 32'h23456780) begin errors++; $display("FAIL sll_upper_b Y=%h required 23456780", Y); end
    issue(32'h80000000, 32'h0000001F, 4'b1011);
    checks++;
    if (Y !== 32'h1) begin errors++; $display("FAIL srl_max Y=%h required 1", Y); end
  endtask

  task automatic test_illegal;
    logic [3:0] ops [4];
    ops = '{4'b0011, 4'b1101, 4'b1110, 4'b1111};
    for (int i = 0; i < 4; i++) begin
      issue(32'hDEADBEEF, 32'h80000001, ops[i]);
      checks++;
      if (Y !== 32'h0 || {Overflow, Carry, Zero, Illegal} !== 4'b0011) begin
        errors++;
        $display("FAIL illegal_%b Y=%h OCZI=%b%b%b%b required 0 0011", ops[i], Y, Overflow, Carry, Zero, Illegal);
      end
    end
  endtask

  task automatic test_back_to_back;
    int nxt;
    idle_clear(2);
    nxt = 0;
    for (int k = 0; k < 12; k++) begin
      if (k < 10) begin
        A = k; B = 32'd100; F = 4'b0010; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== (k >= 1 && k <= 10)) begin
        errors++; $display("FAIL b2b_valid cycle %0d got %b required %b", k, out_valid, (k >= 1 && k <= 10));
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (Y !== 32'd100 + nxt) begin
          errors++; $display("FAIL b2b_order beat %0d Y=%0d required %0d", nxt, Y, 100 + nxt);
        end
        nxt++;
      end
    end
    checks++;
    if (op_count !== 16'd10 || nxt != 10) begin
      errors++; $display("FAIL b2b_count cnt=%0d seen=%0d required 10 10", op_count, nxt);
    end
  endtask

  task automatic test_backpressure;
    int got;
    idle_clear(2);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0 got %b required 1", in_ready); end
    A = 32'd1000; B = 32'd0; F = 4'b0010; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %b required 1", in_ready); end
    A = 32'd1000; B = 32'd2; F = 4'b0010;
    @(posedge clk); #1;
    A = 32'd1000; B = 32'd4; F = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || Y !== 32'd1000 || Zero !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall cycle %0d ready=%b valid=%b Y=%0d required 0 1 1000", c, in_ready, out_valid, Y);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (Y !== 32'd1000 + 2 * got) begin
          errors++; $display("FAIL bp_order beat %0d Y=%0d required %0d", got, Y, 1000 + 2 * got);
        end
        got++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    checks++;
    if (got != 3 || op_count !== 16'd3) begin
      errors++; $display("FAIL bp_count seen=%0d cnt=%0d required 3 3", got, op_count);
    end
  endtask

  task automatic test_clear;
    idle_clear(2);
    issue(32'h7FFFFFFF, 32'h7FFFFFFF, 4'b0010);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checks++;
    if (op_count !== 16'd0 || sticky_ovf !== 1'b0) begin
      errors++; $display("FAIL clear_vs_deliver cnt=%0d sticky=%b required 0 0", op_count, sticky_ovf);
    end
    A = 32'd40; B = 32'd2; F = 4'b0010; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || Y !== 32'd42) begin
      errors++; $display("FAIL clear_no_flush valid=%b Y=%0d required 1 42", out_valid, Y);
    end
    @(posedge clk); #1;
    checks++;
    if (op_count !== 16'd1) begin errors++; $display("FAIL clear_then_count cnt=%0d required 1", op_count); end
  endtask

  task automatic test_reset_midstream;
    A = 32'd7; B = 32'd1; F = 4'b0010; in_valid = 1'b1;
    @(posedge clk); #1;
    A = 32'd9; B = 32'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || op_count !== 16'd0 || sticky_ovf !== 1'b0 || Y !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid valid=%b cnt=%0d sticky=%b Y=%h required 0 0 0 0", out_valid, op_count, sticky_ovf, Y);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || op_count !== 16'd0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid_after cycle %0d valid=%b cnt=%0d ready=%b required 0 0 1", c, out_valid, op_count, in_ready);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clear = 1'b0;
    A = '0; B = '0; F = '0;
    test_reset;
    test_add;
    test_sub_slt;
    test_logic;
    test_shift;
    test_illegal;
    test_back_to_back;
    test_backpressure;
    test_clear;
    test_reset_midstream;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
